// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, default window base and FSM states.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  localparam logic [APB_ADDR_W-1:0] APB_BASE_ADDR = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between one initiator and NUM_SLV responders.
interface apb_master_if #(
  parameter int NUM_SLV = 4
);
  import apb_pkg::*;

  logic [APB_ADDR_W-1:0]               PADDR;
  logic                                PWRITE;
  logic [NUM_SLV-1:0]                  PSEL;
  logic                                PENABLE;
  logic [APB_DATA_W-1:0]               PWDATA;
  logic [NUM_SLV-1:0][APB_DATA_W-1:0]  PRDATA;
  logic [NUM_SLV-1:0]                  PREADY;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto a one-hot responder select and its index.
// Addresses below the window or past the last responder region miss.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                    NUM_SLV       = 4,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR     = APB_BASE_ADDR,
  parameter int                    SLV_SPAN_LOG2 = 12,
  parameter int                    IDX_W         = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [APB_ADDR_W-1:0] addr_i,
  output logic [NUM_SLV-1:0]    sel_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  miss_o
);

  logic [APB_ADDR_W-1:0] offset;
  logic [APB_ADDR_W-1:0] idx_full;

  assign offset   = addr_i - BASE_ADDR;
  assign idx_full = offset >> SLV_SPAN_LOG2;

  // Range check on the full index so high bits that do not fit IDX_W count as a miss.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sel_o  = '0;
    miss_o = (addr_i < BASE_ADDR) || (idx_full >= APB_ADDR_W'(NUM_SLV));
    idx_o  = idx_full[IDX_W-1:0];
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!miss_o && (idx_full == APB_ADDR_W'(i))) sel_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: accepts one load/store request, runs SETUP/ACCESS on the
// decoded responder, and returns a one-cycle ready pulse with data or error.
module apb_master
  import apb_pkg::*;
#(
  parameter int                    NUM_SLV       = 4,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR     = APB_BASE_ADDR,
  parameter int                    SLV_SPAN_LOG2 = 12,
  parameter int                    TIMEOUT_CYC   = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  transfer,
  input  logic [APB_ADDR_W-1:0] addr,
  input  logic                  write,
  input  logic [APB_DATA_W-1:0] wdata,
  output logic [APB_DATA_W-1:0] rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  busy,
  apb_master_if.master          bus
);

  localparam int          IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  apb_state_e            state_q;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic                  pwrite_q;
  logic [APB_DATA_W-1:0] pwdata_q;
  logic [NUM_SLV-1:0]    psel_q;
  logic                  penable_q;
  logic [IDX_W-1:0]      idx_q;
  logic [15:0]           cnt_q;
  logic [APB_DATA_W-1:0] rdata_q;
  logic                  ready_q;
  logic                  err_q;

  logic [NUM_SLV-1:0]    dec_sel;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_miss;
  logic                  sel_ready;
  logic [APB_DATA_W-1:0] sel_rdata;

  apb_addr_decoder #(
    .NUM_SLV      (NUM_SLV),
    .BASE_ADDR    (BASE_ADDR),
    .SLV_SPAN_LOG2(SLV_SPAN_LOG2),
    .IDX_W        (IDX_W)
  ) u_dec (
    .addr_i(addr),
    .sel_o (dec_sel),
    .idx_o (dec_idx),
    .miss_o(dec_miss)
  );

  // Only the responder chosen at request time can complete or return data.
  assign sel_ready = bus.PREADY[idx_q];
  assign sel_rdata = bus.PRDATA[idx_q];

  // Request FSM with registered bus and completion outputs.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      // Completion outputs are single-cycle pulses unless set below.
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            paddr_q  <= addr;
            pwrite_q <= write;
            pwdata_q <= wdata;
            idx_q    <= dec_idx;
            if (dec_miss) begin
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              psel_q  <= dec_sel;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            rdata_q   <= pwrite_q ? '0 : sel_rdata;
            ready_q   <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else if (cnt_q == TO_LAST) begin
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          psel_q    <= '0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule
